// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching-engine feeder: widths,
// buffer depth defaults, FSM state encoding and special characters.
package sme_pkg;

  localparam int CHAR_W      = 8;
  localparam int IDX_W       = 5;
  localparam int MAX_STR_DEF = 32;
  localparam int MAX_PAT_DEF = 8;

  // Pattern metacharacters understood by the engine
  localparam logic [CHAR_W-1:0] CH_DOT    = 8'd46;
  localparam logic [CHAR_W-1:0] CH_DOLLAR = 8'd36;
  localparam logic [CHAR_W-1:0] CH_CARET  = 8'd94;
  localparam logic [CHAR_W-1:0] CH_SPACE  = 8'd32;

  // Feeder state encoding
  typedef logic [2:0] sme_state_t;
  localparam sme_state_t ST_IDLE     = 3'd0;
  localparam sme_state_t ST_SEND_STR = 3'd1;
  localparam sme_state_t ST_SEND_PAT = 3'd2;
  localparam sme_state_t ST_WAIT_RES = 3'd3;
  localparam sme_state_t ST_DONE     = 3'd4;

  // The feeder is busy in every state except IDLE
  function automatic logic state_busy(input sme_state_t st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/sme_char_buf.sv
// Depth-N byte buffer with an append-only length counter. Writes to a full
// buffer are dropped and reported through o_drop for one cycle.
module sme_char_buf
  import sme_pkg::*;
#(
  parameter  int DEPTH = MAX_PAT_DEF,
  parameter  int W     = CHAR_W,
  localparam int LEN_W = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [W-1:0]     i_wr_data,
  input  logic [AW-1:0]    i_rd_idx,
  output logic [W-1:0]     o_rd_data,
  output logic [LEN_W-1:0] o_len,
  output logic             o_drop
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [LEN_W-1:0] r_len;
  logic             w_full;

  assign w_full    = (r_len == LEN_W'(DEPTH));
  assign o_drop    = i_wr_en & w_full & ~i_clr;
  assign o_rd_data = r_mem[i_rd_idx];
  assign o_len     = r_len;

  // Length counter and storage: clear wins over append, full drops the write
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clr) begin
      r_len <= '0;
    end else if (i_wr_en && !w_full) begin
      r_mem[r_len[AW-1:0]] <= i_wr_data;
      r_len                <= r_len + LEN_W'(1);
    end else begin
      r_len <= r_len;
    end
  end

endmodule

// File: rtl/sme_feeder.sv
// Transmit-side driver for the string-matching engine. Holds one string and
// one pattern written by the host, streams them to the engine, waits for the
// engine result (or a timeout) and hands it back to the host. The string is
// retained across transactions so pattern queries can run back to back.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int MAX_STR = MAX_STR_DEF,
  parameter int MAX_PAT = MAX_PAT_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic              i_wr_sel,
  input  logic [CHAR_W-1:0] i_wr_data,
  input  logic              i_buf_clr,
  input  logic              i_start,
  input  logic              i_reuse_string,
  output logic              o_busy,
  output logic [CHAR_W-1:0] o_chardata,
  output logic              o_isstring,
  output logic              o_ispattern,
  input  logic              i_valid,
  input  logic              i_match,
  input  logic [IDX_W-1:0]  i_match_index,
  output logic              o_res_valid,
  output logic              o_res_match,
  output logic [IDX_W-1:0]  o_res_index,
  output logic              o_res_err,
  output logic              o_ovf
);

  localparam int SLEN_W = $clog2(MAX_STR + 1);
  localparam int PLEN_W = $clog2(MAX_PAT + 1);
  localparam int SIDX_W = $clog2(MAX_STR);
  localparam int PIDX_W = $clog2(MAX_PAT);
  localparam int CNT_W  = (SLEN_W > PLEN_W) ? SLEN_W : PLEN_W;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  // Host-side command decode; a start in the same cycle masks clear/write so
  // the transaction always runs on the lengths it was launched with.
  logic              w_idle;
  logic              w_take_start;
  logic              w_clr_cmd;
  logic              w_wr_cmd;
  logic              w_str_wr;
  logic              w_pat_wr;
  logic              w_pat_clr;
  logic              w_str_drop;
  logic              w_pat_drop;
  logic              w_err_empty;
  logic [SLEN_W-1:0] w_str_len;
  logic [PLEN_W-1:0] w_pat_len;
  logic [CHAR_W-1:0] w_str_rd;
  logic [CHAR_W-1:0] w_pat_rd;

  // Next-state values
  sme_state_t        w_state_nx;
  logic [CNT_W-1:0]  w_idx_nx;
  logic [CNT_W-1:0]  w_idx_inc;
  logic [WAIT_W-1:0] w_wait_nx;
  logic              w_res_match_nx;
  logic [IDX_W-1:0]  w_res_index_nx;
  logic              w_res_err_nx;

  // State and registered outputs
  sme_state_t        r_state;
  logic [CNT_W-1:0]  r_idx;
  logic [WAIT_W-1:0] r_wait;
  logic              r_busy;
  logic [CHAR_W-1:0] r_chardata;
  logic              r_isstring;
  logic              r_ispattern;
  logic              r_res_valid;
  logic              r_res_match;
  logic [IDX_W-1:0]  r_res_index;
  logic              r_res_err;
  logic              r_ovf;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_take_start = w_idle & i_start;
  assign w_clr_cmd    = w_idle & i_buf_clr & ~i_start;
  assign w_wr_cmd     = w_idle & i_wr_en & ~i_buf_clr & ~i_start;
  assign w_str_wr     = w_wr_cmd & ~i_wr_sel;
  assign w_pat_wr     = w_wr_cmd & i_wr_sel;
  // The pattern is consumed by every completed transaction
  assign w_pat_clr    = w_clr_cmd | (r_state == ST_DONE);
  assign w_err_empty  = (w_pat_len == '0) || (!i_reuse_string && (w_str_len == '0));
  assign w_idx_inc    = r_idx + CNT_W'(1);

  sme_char_buf #(.DEPTH(MAX_STR), .W(CHAR_W)) u_str_buf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_clr_cmd),
    .i_wr_en   (w_str_wr),
    .i_wr_data (i_wr_data),
    .i_rd_idx  (w_idx_nx[SIDX_W-1:0]),
    .o_rd_data (w_str_rd),
    .o_len     (w_str_len),
    .o_drop    (w_str_drop)
  );

  sme_char_buf #(.DEPTH(MAX_PAT), .W(CHAR_W)) u_pat_buf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_pat_clr),
    .i_wr_en   (w_pat_wr),
    .i_wr_data (i_wr_data),
    .i_rd_idx  (w_idx_nx[PIDX_W-1:0]),
    .o_rd_data (w_pat_rd),
    .o_len     (w_pat_len),
    .o_drop    (w_pat_drop)
  );

  // Next-state, character index, wait counter and result capture
  always_comb begin
    w_state_nx     = r_state;
    w_idx_nx       = r_idx;
    w_wait_nx      = r_wait;
    w_res_match_nx = r_res_match;
    w_res_index_nx = r_res_index;
    w_res_err_nx   = r_res_err;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_idx_nx  = '0;
          w_wait_nx = '0;
          if (w_err_empty) begin
            w_state_nx     = ST_DONE;
            w_res_err_nx   = 1'b1;
            w_res_match_nx = 1'b0;
            w_res_index_nx = '0;
          end else if (i_reuse_string) begin
            w_state_nx = ST_SEND_PAT;
          end else begin
            w_state_nx = ST_SEND_STR;
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SEND_STR: begin
        if (w_idx_inc == CNT_W'(w_str_len)) begin
          w_state_nx = ST_SEND_PAT;
          w_idx_nx   = '0;
        end else begin
          w_idx_nx = w_idx_inc;
        end
      end
      ST_SEND_PAT: begin
        if (w_idx_inc == CNT_W'(w_pat_len)) begin
          w_state_nx = ST_WAIT_RES;
          w_idx_nx   = '0;
          w_wait_nx  = '0;
        end else begin
          w_idx_nx = w_idx_inc;
        end
      end
      ST_WAIT_RES: begin
        if (i_valid) begin
          w_state_nx     = ST_DONE;
          w_res_match_nx = i_match;
          w_res_index_nx = i_match_index;
          w_res_err_nx   = 1'b0;
        end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
          w_state_nx     = ST_DONE;
          w_res_match_nx = 1'b0;
          w_res_index_nx = '0;
          w_res_err_nx   = 1'b1;
        end else begin
          w_wait_nx = r_wait + WAIT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_idx_nx   = '0;
        w_wait_nx  = '0;
      end
    endcase
  end

  // FSM registers; outputs are registered from the next state so the engine
  // sees the first character in the cycle right after start is sampled
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_chardata  <= '0;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_wait      <= w_wait_nx;
      r_busy      <= state_busy(w_state_nx);
      r_isstring  <= (w_state_nx == ST_SEND_STR);
      r_ispattern <= (w_state_nx == ST_SEND_PAT);
      if (w_state_nx == ST_SEND_STR) begin
        r_chardata <= w_str_rd;
      end else if (w_state_nx == ST_SEND_PAT) begin
        r_chardata <= w_pat_rd;
      end else begin
        r_chardata <= '0;
      end
      r_res_valid <= (w_state_nx == ST_DONE);
      r_res_match <= w_res_match_nx;
      r_res_index <= w_res_index_nx;
      r_res_err   <= w_res_err_nx;
    end
  end

  // Sticky overflow flag: cleared by an accepted start or a buffer clear
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ovf <= 1'b0;
    end else if (w_take_start || w_clr_cmd) begin
      r_ovf <= 1'b0;
    end else if (w_str_drop || w_pat_drop) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign o_busy      = r_busy;
  assign o_chardata  = r_chardata;
  assign o_isstring  = r_isstring;
  assign o_ispattern = r_ispattern;
  assign o_res_valid = r_res_valid;
  assign o_res_match = r_res_match;
  assign o_res_index = r_res_index;
  assign o_res_err   = r_res_err;
  assign o_ovf       = r_ovf;

endmodule
